// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-add MUL/IMUL sequencer driving the shared 16-bit ALU
// MUL_SIGNED_EN enables IMUL (operand abs-value, NEG_LO/NEG_HI product negation).
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

module mul_sequencer (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          is_8_bit,
  input  logic                          is_signed,
  input  logic [15:0]                   multiplicand,
  input  logic [15:0]                   multiplier,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   result_hi,
  output logic [15:0]                   result_lo,
  output logic                          overflow,
  output logic [15:0]                   alu_a,
  output logic [15:0]                   alu_b,
  output logic [`MC_ALUOp_t_BITS-1:0]   alu_op,
  output logic                          alu_is_8_bit,
  output logic [15:0]                   alu_flags_in,
  input  logic [15:0]                   alu_out,
  input  logic [15:0]                   alu_flags_out
);
  localparam logic [`MC_ALUOp_t_BITS-1:0] ALUOp_SELA = `MC_ALUOp_t_BITS'(0);
  localparam logic [`MC_ALUOp_t_BITS-1:0] ALUOp_ADD  = `MC_ALUOp_t_BITS'(1);
  localparam logic [`MC_ALUOp_t_BITS-1:0] ALUOp_ADC  = `MC_ALUOp_t_BITS'(2);
  localparam int CF_IDX = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_ITERATE, S_NEG_LO, S_NEG_HI, S_DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] p;
  logic [31:0] p_next;
  logic [15:0] mcand;
  logic        mode_8;
  logic        accept;
  logic [15:0] mc_op;
  logic [15:0] mp_op;
  logic        neg_in;
  logic        sgn_in;

  assign accept       = start && (state == S_IDLE || state == S_DONE);
  assign p_next       = {alu_flags_out[CF_IDX], alu_out, p[15:1]};
  assign alu_is_8_bit = 1'b0;

  function automatic logic ovf_calc(input logic m8, input logic sg,
                                    input logic [15:0] hi, input logic [15:0] lo);
    logic r;
    if (m8) r = sg ? (lo[15:8] != {8{lo[7]}}) : (lo[15:8] != 8'h00);
    else    r = sg ? (hi != {16{lo[15]}})     : (hi != 16'h0000);
    return r;
  endfunction

`ifdef MUL_SIGNED_EN
  logic        sgn;
  logic        neg;
  logic        cf_lat;
  logic        mc_sign;
  logic        mp_sign;
  logic [7:0]  mc_neg8;
  logic [7:0]  mp_neg8;
  logic        unused_sig;

  // Absolute value at the operand width; 8-bit results stay zero-extended
  always_comb begin
    mc_sign = is_8_bit ? multiplicand[7] : multiplicand[15];
    mp_sign = is_8_bit ? multiplier[7]   : multiplier[15];
    mc_neg8 = ~multiplicand[7:0] + 8'd1;
    mp_neg8 = ~multiplier[7:0] + 8'd1;
    mc_op   = is_8_bit ? {8'h00, multiplicand[7:0]} : multiplicand;
    mp_op   = is_8_bit ? {8'h00, multiplier[7:0]}   : multiplier;
    if (is_signed && mc_sign) mc_op = is_8_bit ? {8'h00, mc_neg8} : (~multiplicand + 16'd1);
    if (is_signed && mp_sign) mp_op = is_8_bit ? {8'h00, mp_neg8} : (~multiplier + 16'd1);
    sgn_in  = is_signed;
    neg_in  = is_signed && (mc_sign ^ mp_sign);
  end
  assign unused_sig = ^alu_flags_out[15:1];
`else
  logic unused_sig;
  always_comb begin
    mc_op  = is_8_bit ? {8'h00, multiplicand[7:0]} : multiplicand;
    mp_op  = is_8_bit ? {8'h00, multiplier[7:0]}   : multiplier;
    sgn_in = 1'b0;
    neg_in = 1'b0;
  end
  assign unused_sig = ^{alu_flags_out[15:1], is_signed, sgn_in, neg_in};
`endif

  always_comb begin
    alu_a        = 16'h0000;
    alu_b        = 16'h0000;
    alu_op       = ALUOp_SELA;
    alu_flags_in = 16'h0000;
    case (state)
      S_ITERATE: begin
        alu_a  = p[31:16];
        alu_b  = p[0] ? mcand : 16'h0000;
        alu_op = ALUOp_ADD;
      end
`ifdef MUL_SIGNED_EN
      S_NEG_LO: begin
        alu_a  = ~result_lo;
        alu_b  = 16'h0001;
        alu_op = ALUOp_ADD;
      end
      S_NEG_HI: begin
        alu_a                = ~result_hi;
        alu_op               = ALUOp_ADC;
        alu_flags_in[CF_IDX] = cf_lat;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      result_hi <= 16'h0000;
      result_lo <= 16'h0000;
      p         <= 32'h0;
      cnt       <= 5'd0;
      mcand     <= 16'h0000;
      mode_8    <= 1'b0;
`ifdef MUL_SIGNED_EN
      sgn       <= 1'b0;
      neg       <= 1'b0;
      cf_lat    <= 1'b0;
`endif
    end else begin
      case (state)
        S_ITERATE: begin
          p   <= p_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result_hi <= mode_8 ? 16'h0000 : p_next[31:16];
            result_lo <= mode_8 ? p_next[23:8] : p_next[15:0];
`ifdef MUL_SIGNED_EN
            if (neg) begin
              state <= S_NEG_LO;
            end else
`endif
            begin
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
`ifdef MUL_SIGNED_EN
              overflow <= ovf_calc(mode_8, sgn, mode_8 ? 16'h0000 : p_next[31:16],
                                   mode_8 ? p_next[23:8] : p_next[15:0]);
`else
              overflow <= ovf_calc(mode_8, 1'b0, mode_8 ? 16'h0000 : p_next[31:16],
                                   mode_8 ? p_next[23:8] : p_next[15:0]);
`endif
            end
          end
        end
`ifdef MUL_SIGNED_EN
        S_NEG_LO: begin
          result_lo <= alu_out;
          cf_lat    <= alu_flags_out[CF_IDX];
          if (mode_8) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= ovf_calc(1'b1, sgn, result_hi, alu_out);
          end else begin
            state <= S_NEG_HI;
          end
        end
        S_NEG_HI: begin
          result_hi <= alu_out;
          state     <= S_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          overflow  <= ovf_calc(1'b0, sgn, alu_out, result_lo);
        end
`endif
        default: begin
          // IDLE and DONE both accept a new request
          done <= 1'b0;
          if (accept) begin
            state  <= S_ITERATE;
            busy   <= 1'b1;
            mode_8 <= is_8_bit;
            cnt    <= is_8_bit ? 5'd8 : 5'd16;
            p      <= {16'h0000, mp_op};
            mcand  <= mc_op;
`ifdef MUL_SIGNED_EN
            sgn    <= sgn_in;
            neg    <= neg_in;
`endif
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
